// File: rtl/uart_rx_framer.sv
// 8N1 UART receiver: 2-FF synchronised input, mid-bit sampling, LSB first,
// valid/ack byte handshake with framing-error, overrun and false-start handling.
module uart_rx_framer #(
   parameter int CLKS_PER_BIT = 10416,
   parameter int HALF_BIT     = 5208
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       RXD_i,
   output logic [7:0] data_o,
   output logic       data_valid_o,
   input  logic       data_ack_i,
   output logic       frame_err_o,
   output logic       overrun_o,
   output logic       busy_o
);
   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} state_t;

   localparam logic [13:0] BIT_LAST  = 14'(CLKS_PER_BIT - 1);
   localparam logic [13:0] HALF_LAST = 14'(HALF_BIT - 1);

   state_t      state, state_nxt;
   logic [13:0] cnt, cnt_nxt;
   logic [2:0]  idx, idx_nxt;
   logic [7:0]  shreg, shreg_nxt;
   logic        rx_meta, rxs;
   logic        load, ferr;

   // Synchroniser resets to the idle level so reset release never looks like a start bit
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= RXD_i;
         rxs     <= rx_meta;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         idx          <= '0;
         shreg        <= '0;
         data_o       <= '0;
         data_valid_o <= 1'b0;
         frame_err_o  <= 1'b0;
         overrun_o    <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         idx          <= idx_nxt;
         shreg        <= shreg_nxt;
         if (load) data_o <= shreg;
         // A load in the same cycle as an ack wins: valid stays up, no overrun
         data_valid_o <= load | (data_valid_o & ~data_ack_i);
         frame_err_o  <= ferr;
         overrun_o    <= load & data_valid_o & ~data_ack_i;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      shreg_nxt = shreg;
      load      = 1'b0;
      ferr      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!rxs) begin
               state_nxt = ST_START;
               cnt_nxt   = '0;
            end
         end
         ST_START: begin
            if (cnt == HALF_LAST) begin
               cnt_nxt   = '0;
               idx_nxt   = '0;
               state_nxt = rxs ? ST_IDLE : ST_DATA;
            end else begin
               cnt_nxt = cnt + 14'd1;
            end
         end
         ST_DATA: begin
            if (cnt == BIT_LAST) begin
               shreg_nxt = {rxs, shreg[7:1]};
               cnt_nxt   = '0;
               idx_nxt   = idx + 3'd1;
               if (idx == 3'd7) state_nxt = ST_STOP;
            end else begin
               cnt_nxt = cnt + 14'd1;
            end
         end
         ST_STOP: begin
            // Decide at mid-stop so IDLE is re-armed half a bit before the next start
            if (cnt == BIT_LAST) begin
               cnt_nxt = '0;
               if (rxs) begin
                  load      = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  ferr      = 1'b1;
                  state_nxt = ST_BREAK;
               end
            end else begin
               cnt_nxt = cnt + 14'd1;
            end
         end
         ST_BREAK: begin
            if (rxs) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign busy_o = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer with shortened bit timing; an event-level
// model (frame -> outcome at start + latency) is compared every cycle.
module tb_uart_rx_framer;
   localparam int CPB = 16;
   localparam int HALF = 8;
   localparam int LAT = 3 + HALF + 9 * CPB;  // 155 cycles from falling edge to valid

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b0;
   logic       RXD_i = 1'b1;
   logic       data_ack_i = 1'b0;
   logic [7:0] data_o;
   logic       data_valid_o, frame_err_o, overrun_o, busy_o;

   uart_rx_framer #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .RXD_i(RXD_i),
      .data_o(data_o), .data_valid_o(data_valid_o), .data_ack_i(data_ack_i),
      .frame_err_o(frame_err_o), .overrun_o(overrun_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct { int due; bit ferr; logic [7:0] b; } ev_t;
   ev_t evq[$];

   int checks = 0, failures = 0, cyc = 0;
   int valid_rise = -1, ferr_cnt = 0, ovr_cnt = 0;
   logic [7:0] m_data = 8'h00, ev_b;
   bit m_valid, m_ferr, m_ovr, prev_ack, last_valid, ev_ld, ev_fe;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic tick(int n);
      repeat (n) begin @(posedge clk_i); #1; end
   endtask

   task automatic ack_pulse();
      data_ack_i = 1'b1; tick(1); data_ack_i = 1'b0;
   endtask

   task automatic send_frame(logic [7:0] b, bit stop, output int k);
      k = cyc;
      evq.push_back('{due: k + LAT, ferr: !stop, b: b});
      RXD_i = 1'b0; tick(CPB);
      for (int i = 0; i < 8; i++) begin RXD_i = b[i]; tick(CPB); end
      RXD_i = stop; tick(CPB);
   endtask

   initial forever begin @(posedge clk_i); cyc++; end

   // Model state after edge `cyc`, then compare against the DUT
   initial forever begin
      @(negedge clk_i);
      if (!rst_i) begin
         m_data = 8'h00; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
         evq.delete();
      end else begin
         ev_ld = 1'b0; ev_fe = 1'b0; ev_b = 8'h00;
         for (int i = evq.size() - 1; i >= 0; i--) begin
            if (evq[i].due == cyc) begin
               if (evq[i].ferr) ev_fe = 1'b1;
               else begin ev_ld = 1'b1; ev_b = evq[i].b; end
               evq.delete(i);
            end
         end
         m_ferr = ev_fe;
         m_ovr  = ev_ld && m_valid && !prev_ack;
         if (ev_ld) begin m_data = ev_b; m_valid = 1'b1; end
         else if (prev_ack) m_valid = 1'b0;
      end
      prev_ack = data_ack_i;
      check("outputs{data,valid,ferr,ovr}",
            32'({data_o, data_valid_o, frame_err_o, overrun_o}),
            32'({m_data, m_valid, m_ferr, m_ovr}));
      if (data_valid_o && !last_valid) valid_rise = cyc;
      last_valid = data_valid_o;
      if (frame_err_o) ferr_cnt++;
      if (overrun_o) ovr_cnt++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k;
      tick(3);
      check("reset_data", 32'(data_o), 32'h00);
      check("reset_valid", 32'(data_valid_o), 32'd0);
      check("reset_ferr", 32'(frame_err_o), 32'd0);
      check("reset_ovr", 32'(overrun_o), 32'd0);
      check("reset_busy", 32'(busy_o), 32'd0);
      rst_i = 1'b1; tick(5);

      // 1: single frame 0x3D, latency check
      valid_rise = -1;
      send_frame(8'h3D, 1'b1, k);
      tick(5);
      check("t1_data", 32'(data_o), 32'h3D);
      check("t1_valid", 32'(data_valid_o), 32'd1);
      checks++;
      if (valid_rise < k + 153 || valid_rise > k + 157) begin
         failures++;
         $display("FAIL t1_latency: got %0d expected 155+-2", valid_rise - k);
      end
      check("t1_busy", 32'(busy_o), 32'd0);
      check("t1_errs", 32'(ferr_cnt + ovr_cnt), 32'd0);

      // 2: 0x02 loaded in the same cycle the consumer acks 0x3D
      fork
         send_frame(8'h02, 1'b1, k);
         begin tick(LAT - 1); ack_pulse(); end
      join
      tick(5);
      check("t2_data", 32'(data_o), 32'h02);
      check("t2_valid", 32'(data_valid_o), 32'd1);
      check("t2_ovr", 32'(ovr_cnt), 32'd0);
      ack_pulse(); tick(2);
      check("t2_acked", 32'(data_valid_o), 32'd0);
      ack_pulse(); tick(2);
      check("t2_idle_ack", 32'(data_valid_o), 32'd0);

      // 3: back-to-back 0x55, 0xAA without ack
      send_frame(8'h55, 1'b1, k);
      send_frame(8'hAA, 1'b1, k);
      tick(5);
      check("t3_ovr_cnt", 32'(ovr_cnt), 32'd1);
      check("t3_data", 32'(data_o), 32'hAA);
      check("t3_valid", 32'(data_valid_o), 32'd1);
      ack_pulse(); tick(2);

      // 4: framing error, held-low line, then recovery
      send_frame(8'h81, 1'b0, k);
      tick(3 * CPB);
      check("t4_ferr_cnt", 32'(ferr_cnt), 32'd1);
      check("t4_valid", 32'(data_valid_o), 32'd0);
      check("t4_break_busy", 32'(busy_o), 32'd1);
      RXD_i = 1'b1; tick(5);
      check("t4_break_exit", 32'(busy_o), 32'd0);
      send_frame(8'h3C, 1'b1, k);
      tick(5);
      check("t4_data", 32'(data_o), 32'h3C);
      check("t4_valid2", 32'(data_valid_o), 32'd1);
      check("t4_ferr_once", 32'(ferr_cnt), 32'd1);

      // 5: short glitch -> false start
      RXD_i = 1'b0; tick(3); RXD_i = 1'b1; tick(2);
      check("t5_busy_start", 32'(busy_o), 32'd1);
      tick(20);
      check("t5_busy_idle", 32'(busy_o), 32'd0);
      check("t5_errs", 32'(ferr_cnt + ovr_cnt), 32'd2);
      check("t5_data", 32'(data_o), 32'h3C);

      // 6: reset mid-DATA, then a clean frame
      RXD_i = 1'b0; tick(CPB + 2 * CPB);
      check("t6_busy_data", 32'(busy_o), 32'd1);
      rst_i = 1'b0; RXD_i = 1'b1; tick(1);
      check("t6_rst_data", 32'(data_o), 32'h00);
      check("t6_rst_valid", 32'(data_valid_o), 32'd0);
      check("t6_rst_busy", 32'(busy_o), 32'd0);
      tick(9); rst_i = 1'b1; tick(5);
      send_frame(8'hF0, 1'b1, k);
      tick(5);
      check("t6_data", 32'(data_o), 32'hF0);
      check("t6_valid", 32'(data_valid_o), 32'd1);
      check("t6_ovr", 32'(ovr_cnt), 32'd1);
      tick(10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
